// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory port arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_MAX_STARVE = 4;
endpackage

// File: rtl/arb_pick.sv
// Winner selection: data wins unless fetch has lost MAX_STARVE arbitrations in a row.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int SW         = $clog2(MAX_STARVE + 1)
) (
  input  logic          f_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output owner_t        winner
);
  logic f_forced;

  assign f_forced = f_req && (starve_cnt == SW'(MAX_STARVE));

  always_comb begin
    winner = OWN_F;
    if (d_req && !f_forced) winner = OWN_D;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch (read-only) and data (read/write) requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt, winner;
  logic          owner_we, owner_we_nxt;
  logic [LW-1:0] lat_cnt, lat_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          resp, grant;

  arb_pick #(.MAX_STARVE(MAX_STARVE), .SW(SW)) u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .winner     (winner)
  );

  // The response cycle doubles as an idle cycle so back-to-back grants lose no throughput.
  assign resp  = (state == BUSY) && (lat_cnt == LW'(1));
  assign grant = !rst && ((state == IDLE) || resp) && (f_req || d_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_F;
      owner_we   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      owner_we   <= owner_we_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    owner_we_nxt = owner_we;
    lat_nxt      = lat_cnt;
    starve_nxt   = starve_cnt;
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    f_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    f_rdata      = '0;
    d_rdata      = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;

    if (state == BUSY) begin
      lat_nxt = lat_cnt - LW'(1);
      if (resp) state_nxt = IDLE;
    end

    if (resp) begin
      if (owner == OWN_F) begin
        f_rvalid = 1'b1;
        f_rdata  = mem_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = owner_we ? '0 : mem_rdata;
      end
    end

    if (grant) begin
      state_nxt = BUSY;
      lat_nxt   = LW'(MEM_LAT);
      owner_nxt = winner;
      mem_en    = 1'b1;
      if (winner == OWN_D) begin
        d_gnt        = 1'b1;
        mem_we       = d_we;
        mem_addr     = d_addr;
        mem_wdata    = d_wdata;
        mem_wmask    = d_wmask;
        owner_we_nxt = d_we;
        if (f_req && (starve_cnt != SW'(MAX_STARVE))) starve_nxt = starve_cnt + SW'(1);
      end else begin
        f_gnt        = 1'b1;
        mem_addr     = f_addr;
        owner_we_nxt = 1'b0;
        starve_nxt   = '0;
      end
    end
  end

  assign stall = !rst && (((state == BUSY) && !resp) || ((f_req || d_req) && !(f_gnt || d_gnt)));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, starvation and MEM_LAT=1 sequences.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        f_gnt;
    logic        d_gnt;
    logic        f_rvalid;
    logic        d_rvalid;
    logic [31:0] f_rdata;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        stall;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        f_req, d_req, d_we, f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, stall;
  logic [31:0] f_addr, d_addr, d_wdata, f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_wmask, mem_wmask;

  logic        o_f_req, o_d_req, o_d_we, o_f_gnt, o_d_gnt, o_f_rvalid, o_d_rvalid;
  logic        o_mem_en, o_mem_we, o_stall;
  logic [31:0] o_f_addr, o_d_addr, o_d_wdata, o_f_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic [3:0]  o_d_wmask, o_mem_wmask;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STARVE(4)) dut_lat1 (
    .clk(clk), .rst(rst),
    .f_req(o_f_req), .f_addr(o_f_addr), .f_gnt(o_f_gnt), .f_rvalid(o_f_rvalid), .f_rdata(o_f_rdata),
    .d_req(o_d_req), .d_we(o_d_we), .d_addr(o_d_addr), .d_wdata(o_d_wdata), .d_wmask(o_d_wmask),
    .d_gnt(o_d_gnt), .d_rvalid(o_d_rvalid), .d_rdata(o_d_rdata),
    .mem_en(o_mem_en), .mem_we(o_mem_we), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata),
    .mem_wmask(o_mem_wmask), .mem_rdata(o_mem_rdata), .stall(o_stall)
  );

  // Requesters must hold their payload while waiting for a grant.
  logic        f_pend, d_pend;
  logic [31:0] f_pa;
  logic [100:0] d_pa;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_pend <= 1'b0;
      d_pend <= 1'b0;
      f_pa   <= '0;
      d_pa   <= '0;
    end else begin
      if (f_pend && f_req)
        assert (f_addr == f_pa) else $error("fetch payload changed while pending");
      if (d_pend && d_req)
        assert ({d_we, d_addr, d_wdata, d_wmask} == d_pa) else $error("data payload changed while pending");
      f_pend <= f_req && !f_gnt;
      d_pend <= d_req && !d_gnt;
      f_pa   <= f_addr;
      d_pa   <= {d_we, d_addr, d_wdata, d_wmask};
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic apply(input in_t v);
    f_req     = v.f_req;
    f_addr    = v.f_addr;
    d_req     = v.d_req;
    d_we      = v.d_we;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    d_wmask   = v.d_wmask;
    mem_rdata = v.mem_rdata;
  endtask

  function automatic exp_t outs();
    exp_t g;
    g = {f_gnt, d_gnt, f_rvalid, d_rvalid, f_rdata, d_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, mem_wmask, stall};
    return g;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    int dcnt;
    bit fseen, hit;

    apply('0);
    o_f_req = 1'b0; o_f_addr = '0; o_d_req = 1'b0; o_d_we = 1'b0;
    o_d_addr = '0; o_d_wdata = '0; o_d_wmask = '0; o_mem_rdata = '0;

    vecs[0]  = '{i: '0, e: '0};
    vecs[1]  = '{i: '{f_req: 1'b1, f_addr: 32'h100, default: '0},
                 e: '{f_gnt: 1'b1, mem_en: 1'b1, mem_addr: 32'h100, default: '0}};
    vecs[2]  = '{i: '0, e: '{stall: 1'b1, default: '0}};
    vecs[3]  = '{i: '{mem_rdata: 32'h1111_1111, default: '0},
                 e: '{f_rvalid: 1'b1, f_rdata: 32'h1111_1111, default: '0}};
    vecs[4]  = '{i: '{f_req: 1'b1, f_addr: 32'h300, d_req: 1'b1, d_addr: 32'h200, default: '0},
                 e: '{d_gnt: 1'b1, mem_en: 1'b1, mem_addr: 32'h200, default: '0}};
    vecs[5]  = '{i: '{f_req: 1'b1, f_addr: 32'h300, default: '0},
                 e: '{stall: 1'b1, default: '0}};
    vecs[6]  = '{i: '{f_req: 1'b1, f_addr: 32'h300, mem_rdata: 32'h2222_2222, default: '0},
                 e: '{d_rvalid: 1'b1, d_rdata: 32'h2222_2222, f_gnt: 1'b1, mem_en: 1'b1,
                      mem_addr: 32'h300, default: '0}};
    vecs[7]  = '{i: '0, e: '{stall: 1'b1, default: '0}};
    vecs[8]  = '{i: '{mem_rdata: 32'h3333_3333, default: '0},
                 e: '{f_rvalid: 1'b1, f_rdata: 32'h3333_3333, default: '0}};
    vecs[9]  = '{i: '{d_req: 1'b1, d_we: 1'b1, d_addr: 32'h400, d_wdata: 32'hDEAD_BEEF,
                      d_wmask: 4'b0011, default: '0},
                 e: '{d_gnt: 1'b1, mem_en: 1'b1, mem_we: 1'b1, mem_addr: 32'h400,
                      mem_wdata: 32'hDEAD_BEEF, mem_wmask: 4'b0011, default: '0}};
    vecs[10] = '{i: '0, e: '{stall: 1'b1, default: '0}};
    vecs[11] = '{i: '{mem_rdata: 32'h4444_4444, default: '0},
                 e: '{d_rvalid: 1'b1, default: '0}};
    vecs[12] = '{i: '0, e: '0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].i);
      @(negedge clk);
      check($sformatf("vec%0d", i), 256'(outs()), 256'(vecs[i].e));
      next_cycle();
    end

    // Starvation: fetch held while data requests continuously.
    f_req = 1'b1; f_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_wdata = '0; d_wmask = '0;
    mem_rdata = 32'h5555_5555;
    dcnt = 0; fseen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_gnt) dcnt++;
      if (f_gnt) begin
        fseen = 1'b1;
        break;
      end
      next_cycle();
    end
    check("starve_f_granted", 256'(fseen), 256'(1'b1));
    check("starve_d_grants", 256'(dcnt), 256'(4));
    next_cycle();
    f_req = 1'b0;
    next_cycle();
    f_req = 1'b1; f_addr = 32'h504;
    hit = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (f_gnt || d_gnt) begin
        hit = 1'b1;
        check("starve_cleared_d_wins", 256'({f_gnt, d_gnt}), 256'(2'b01));
        break;
      end
      next_cycle();
    end
    if (!hit) check("starve_cleared_timeout", 256'(1'b0), 256'(1'b1));
    next_cycle();
    d_req = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (f_gnt) begin
        hit = 1'b1;
        break;
      end
      next_cycle();
    end
    check("starve_f_after_d", 256'(hit), 256'(1'b1));
    next_cycle();
    f_req = 1'b0;
    repeat (3) next_cycle();

    // Reset while a load is in flight.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; mem_rdata = 32'h8888_8888;
    @(negedge clk);
    check("rst_load_gnt", 256'(d_gnt), 256'(1'b1));
    next_cycle();
    d_req = 1'b0;
    f_req = 1'b1; f_addr = 32'h900;
    #2 rst = 1'b1;
    #1 check("rst_outputs_zero", 256'(outs()), 256'(0));
    repeat (2) @(posedge clk);
    #1 f_req = 1'b0;
    #1 rst = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (d_rvalid || f_rvalid || mem_en) hit = 1'b1;
      next_cycle();
    end
    check("rst_no_rvalid", 256'(hit), 256'(1'b0));

    // MEM_LAT=1 back-to-back loads.
    o_d_req = 1'b1; o_d_we = 1'b0; o_d_addr = 32'h700;
    for (int k = 0; k < 6; k++) begin
      o_mem_rdata = 32'h1000 + 32'(k);
      @(negedge clk);
      check($sformatf("lat1_cycle%0d", k),
            256'({o_d_gnt, o_stall, o_d_rvalid, o_d_rdata, o_mem_en, o_mem_addr}),
            256'({1'b1, 1'b0, (k > 0), (k > 0) ? 32'h1000 + 32'(k) : 32'h0, 1'b1, 32'h700}));
      next_cycle();
    end
    o_d_req = 1'b0;
    repeat (2) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
